tile_accumulation_buffer: RTL and testbench

Banked accumulation buffer that sits directly downstream of the neighbour input processor and receives its per-bank write ports. Each write is a signed 8-bit partial product that is added into an accumulator at (row, column) of the output tile. On command, the buffer drains the full tile in row-major order through a valid/ready stream, clearing each entry as it is read. It then self-clears ready for the next tile.

---
 rtl/tile_accumulation_buffer_pkg.sv | 36 +++
 rtl/tile_accumulation_buffer_if.sv | 41 ++++
 rtl/tile_accumulation_buffer_bank.sv | 35 +++
 rtl/tile_accumulation_buffer.sv | 179 +++++++++++++++++
 tb/tb_tile_accumulation_buffer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tile_accumulation_buffer_pkg.sv
// Shared types and bank mapping helpers for the tile accumulation buffer.
// Also used by the neighbour input processor to steer writes to banks.
package tile_accumulation_buffer_pkg;

   typedef enum logic [1:0] {
      CLEAR,
      IDLE,
      FLUSH,
      DRAIN
   } state_e;

   function automatic int bank_from_rc(
      input int row,
      input int col,
      input int banks
   );
      return (col + 3 * row) % banks;
   endfunction

   function automatic int addr_from_rc(
      input int row,
      input int col,
      input int tile,
      input int banks
   );
      return row * (tile / banks) + col / banks;
   endfunction

   function automatic int depth_of(
      input int tile,
      input int banks
   );
      return (tile * tile) / banks;
   endfunction

endpackage

// File: rtl/tile_accumulation_buffer_if.sv
// Write ports, drain control and readout stream of the accumulation buffer.
// master drives writes/drain_start/out_ready; slave is the buffer.
interface tile_accumulation_buffer_if #(
   parameter int BANK_COUNT = 32,
   parameter int TILE_SIZE  = 256,
   parameter int ACC_WIDTH  = 24
);
   localparam int CW = $clog2(TILE_SIZE);

   logic [CW-1:0]        buffer_row_write    [BANK_COUNT];
   logic [CW-1:0]        buffer_column_write [BANK_COUNT];
   logic [7:0]           buffer_data_write   [BANK_COUNT];
   logic                 buffer_write_enable [BANK_COUNT];
   logic                 drain_start;
   logic                 out_ready;
   logic                 out_valid;
   logic [CW-1:0]        out_row;
   logic [CW-1:0]        out_col;
   logic [ACC_WIDTH-1:0] out_data;
   logic                 drain_done;
   logic                 write_ready;
   logic                 dropped_write;
   logic                 busy;

   modport master (
      output buffer_row_write, buffer_column_write,
      output buffer_data_write, buffer_write_enable,
      output drain_start, out_ready,
      input  out_valid, out_row, out_col, out_data,
      input  drain_done, write_ready, dropped_write, busy
   );

   modport slave (
      input  buffer_row_write, buffer_column_write,
      input  buffer_data_write, buffer_write_enable,
      input  drain_start, out_ready,
      output out_valid, out_row, out_col, out_data,
      output drain_done, write_ready, dropped_write, busy
   );

endinterface

// File: rtl/tile_accumulation_buffer_bank.sv
// One accumulator bank: registered accumulate, sweep clear, read-and-clear.
// Array reads are combinational so back-to-back accumulates chain.
module tile_buffer_bank #(
   parameter int DEPTH     = 16,
   parameter int ACC_WIDTH = 24,
   parameter int AW        = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 acc_en,
   input  logic [AW-1:0]        acc_addr,
   input  logic [7:0]           acc_data,
   input  logic                 clr_en,
   input  logic [AW-1:0]        clr_addr,
   input  logic                 rd_en,
   input  logic [AW-1:0]        rd_addr,
   output logic [ACC_WIDTH-1:0] rd_data
);

   logic [ACC_WIDTH-1:0] mem [DEPTH];
   logic [ACC_WIDTH-1:0] ext;

   assign ext     = {{(ACC_WIDTH-8){acc_data[7]}}, acc_data};
   assign rd_data = mem[rd_addr];

   // The three ports are never active together; priority is defensive.
   always_ff @(posedge clk) begin
      if (clr_en)
         mem[clr_addr] <= '0;
      else if (rd_en)
         mem[rd_addr] <= '0;
      else if (acc_en)
         mem[acc_addr] <= mem[acc_addr] + ext;
   end

endmodule

// File: rtl/tile_accumulation_buffer.sv
// Banked tile accumulator: FSM, write pipeline stage 1, drain sweep and
// readout register. Banks hold the accumulate stage and the storage.
module tile_accumulation_buffer
   import tile_accumulation_buffer_pkg::*;
#(
   parameter int BANK_COUNT = 32,
   parameter int TILE_SIZE  = 256,
   parameter int ACC_WIDTH  = 24
) (
   input logic clk,
   input logic reset_n,
   tile_accumulation_buffer_if.slave bus
);

   localparam int CW    = $clog2(TILE_SIZE);
   localparam int DEPTH = depth_of(TILE_SIZE, BANK_COUNT);
   localparam int AW    = $clog2(DEPTH);
   localparam int BW    = (BANK_COUNT > 1) ? $clog2(BANK_COUNT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TILE_SIZE - 1);

   state_e state_q, state_d;

   logic [AW-1:0]         idx_q;
   logic [CW-1:0]         r_q, c_q;
   logic                  all_loaded_q;
   logic                  out_valid_q;
   logic [CW-1:0]         out_row_q, out_col_q;
   logic [ACC_WIDTH-1:0]  out_data_q;
   logic                  done_q;
   logic                  dropped_q;

   logic                  clr_en, load, finish;
   logic                  write_ready;
   logic [BANK_COUNT-1:0] drop_vec;
   logic [BW-1:0]         rd_bank;
   logic [AW-1:0]         rd_addr;
   logic [ACC_WIDTH-1:0]  rd_data [BANK_COUNT];

   assign write_ready = (state_q == IDLE);

   assign rd_bank = BW'(bank_from_rc(int'(r_q), int'(c_q), BANK_COUNT));
   assign rd_addr = AW'(addr_from_rc(int'(r_q), int'(c_q),
                                     TILE_SIZE, BANK_COUNT));

   for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
      logic          hit;
      logic          en_q;
      logic [CW-1:0] row_q, col_q;
      logic [7:0]    data_q;

      assign hit = bank_from_rc(int'(bus.buffer_row_write[b]),
                                int'(bus.buffer_column_write[b]),
                                BANK_COUNT) == b;

      assign drop_vec[b] = bus.buffer_write_enable[b]
                         && !(write_ready && hit);

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            en_q   <= 1'b0;
            row_q  <= '0;
            col_q  <= '0;
            data_q <= '0;
         end else begin
            en_q   <= bus.buffer_write_enable[b] && write_ready && hit;
            row_q  <= bus.buffer_row_write[b];
            col_q  <= bus.buffer_column_write[b];
            data_q <= bus.buffer_data_write[b];
         end
      end

      tile_buffer_bank #(
         .DEPTH     (DEPTH),
         .ACC_WIDTH (ACC_WIDTH),
         .AW        (AW)
      ) u_bank (
         .clk      (clk),
         .acc_en   (en_q),
         .acc_addr (AW'(addr_from_rc(int'(row_q), int'(col_q),
                                     TILE_SIZE, BANK_COUNT))),
         .acc_data (data_q),
         .clr_en   (clr_en),
         .clr_addr (idx_q),
         .rd_en    (load && (rd_bank == BW'(b))),
         .rd_addr  (rd_addr),
         .rd_data  (rd_data[b])
      );
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state_q <= CLEAR;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      clr_en  = 1'b0;
      load    = 1'b0;
      finish  = 1'b0;
      unique case (state_q)
         CLEAR: begin
            clr_en = 1'b1;
            if (idx_q == AW'(DEPTH - 1))
               state_d = IDLE;
         end
         IDLE: begin
            if (bus.drain_start)
               state_d = FLUSH;
         end
         FLUSH: state_d = DRAIN;
         DRAIN: begin
            if (!out_valid_q || bus.out_ready) begin
               if (all_loaded_q) begin
                  finish  = 1'b1;
                  state_d = IDLE;
               end else begin
                  load = 1'b1;
               end
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_q        <= '0;
         r_q          <= '0;
         c_q          <= '0;
         all_loaded_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_row_q    <= '0;
         out_col_q    <= '0;
         out_data_q   <= '0;
         done_q       <= 1'b0;
         dropped_q    <= 1'b0;
      end else begin
         done_q <= finish;
         if (|drop_vec)
            dropped_q <= 1'b1;
         if (clr_en)
            idx_q <= (idx_q == AW'(DEPTH - 1)) ? '0 : idx_q + 1'b1;
         if (state_q == FLUSH) begin
            r_q          <= '0;
            c_q          <= '0;
            all_loaded_q <= 1'b0;
         end
         if (load) begin
            out_valid_q <= 1'b1;
            out_row_q   <= r_q;
            out_col_q   <= c_q;
            out_data_q  <= rd_data[rd_bank];
            if (c_q == LAST) begin
               c_q <= '0;
               if (r_q == LAST)
                  all_loaded_q <= 1'b1;
               else
                  r_q <= r_q + 1'b1;
            end else begin
               c_q <= c_q + 1'b1;
            end
         end
         if (finish)
            out_valid_q <= 1'b0;
      end
   end

   assign bus.out_valid     = out_valid_q;
   assign bus.out_row       = out_row_q;
   assign bus.out_col       = out_col_q;
   assign bus.out_data      = out_data_q;
   assign bus.drain_done    = done_q;
   assign bus.write_ready   = write_ready;
   assign bus.dropped_write = dropped_q;
   assign bus.busy          = !write_ready;

endmodule

// File: tb/tb_tile_accumulation_buffer.sv
// Scoreboard bench for tile_accumulation_buffer (8x8 tile, 4 banks).
// Reference model is a plain 2-D array of accumulators.
module tb_tile_accumulation_buffer;

   typedef struct packed {
      int          r;
      int          c;
      logic [23:0] d;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   tile_accumulation_buffer_if #(
      .BANK_COUNT (4),
      .TILE_SIZE  (8),
      .ACC_WIDTH  (24)
   ) bus ();

   tile_accumulation_buffer #(
      .BANK_COUNT (4),
      .TILE_SIZE  (8),
      .ACC_WIDTH  (24)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   exp_t        sb[$];
   logic [23:0] mdl [8][8];
   bit          tb_idle = 1'b0;
   bit          exp_dropped = 1'b0;
   int          hs_cnt = 0;
   int          done_cnt = 0;

   bit          held_v = 1'b0;
   logic [2:0]  held_row, held_col;
   logic [23:0] held_data;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic wait_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_en();
      for (int b = 0; b < 4; b++) bus.buffer_write_enable[b] = 1'b0;
   endtask

   task automatic zero_model();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) mdl[r][c] = '0;
   endtask

   task automatic issue(input int b, input int r, input int c, input int d);
      logic [7:0] dd;
      dd = 8'(d);
      bus.buffer_write_enable[b] = 1'b1;
      bus.buffer_row_write[b]    = 3'(r);
      bus.buffer_column_write[b] = 3'(c);
      bus.buffer_data_write[b]   = dd;
      if (tb_idle && ((c + 3 * r) % 4 == b))
         mdl[r][c] = mdl[r][c] + {{16{dd[7]}}, dd};
      else
         exp_dropped = 1'b1;
   endtask

   task automatic commit();
      wait_clk();
      clear_en();
   endtask

   task automatic rand_writes();
      int r, c;
      for (int b = 0; b < 4; b++) begin
         if ($urandom_range(1, 0) == 1) begin
            r = int'($urandom_range(7, 0));
            c = (b + 32 - 3 * r) % 4 + 4 * int'($urandom_range(1, 0));
            issue(b, r, c, int'($urandom_range(255, 0)));
         end
      end
   endtask

   task automatic drive_ready(input int mode, input int i);
      case (mode)
         0: bus.out_ready = 1'b1;
         1: bus.out_ready = (i % 4 == 0) || (i % 4 == 3);
         default: bus.out_ready = 1'($urandom_range(1, 0));
      endcase
   endtask

   task automatic wait_clear();
      int cnt;
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
         wait_clk();
         cnt++;
         if (bus.write_ready) break;
      end
      chk("clear_cycles", cnt, 16);
      chk("idle_busy", 32'(bus.busy), 0);
   endtask

   task automatic drain(input int mode, input bit wr_same,
                        input bit wr_during, input int abort_at);
      int d0;
      bit got;
      if (wr_same) rand_writes();
      chk("idle_ready", 32'(bus.write_ready), 1);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            sb.push_back('{r: r, c: c, d: mdl[r][c]});
            mdl[r][c] = '0;
         end
      hs_cnt = 0;
      d0 = done_cnt;
      bus.drain_start = 1'b1;
      wait_clk();
      clear_en();
      bus.drain_start = 1'b0;
      drive_ready(mode, 0);
      chk("lat0_valid", 32'(bus.out_valid), 0);
      wait_clk();
      drive_ready(mode, 1);
      chk("lat1_valid", 32'(bus.out_valid), 0);
      wait_clk();
      chk("lat2_valid", 32'(bus.out_valid), 1);
      drive_ready(mode, 2);
      got = 1'b0;
      for (int i = 3; i < 2000; i++) begin
         wait_clk();
         clear_en();
         if (abort_at >= 0 && hs_cnt >= abort_at) begin
            #2 reset_n = 1'b0;
            #1;
            chk("rst_valid", 32'(bus.out_valid), 0);
            chk("rst_row", 32'(bus.out_row), 0);
            chk("rst_col", 32'(bus.out_col), 0);
            chk("rst_data", 32'(bus.out_data), 0);
            chk("rst_done", 32'(bus.drain_done), 0);
            chk("rst_wready", 32'(bus.write_ready), 0);
            chk("rst_dropped", 32'(bus.dropped_write), 0);
            chk("rst_busy", 32'(bus.busy), 1);
            return;
         end
         if (bus.drain_done) begin
            got = 1'b1;
            break;
         end
         if (wr_during && i == 5) begin
            tb_idle = 1'b0;
            issue(0, 1, 0, 9);
            issue(3, 1, 0, 7);
            tb_idle = 1'b1;
         end
         drive_ready(mode, i);
      end
      chk("done_seen", 32'(got), 1);
      chk("done_state_idle", 32'(bus.write_ready), 1);
      chk("done_valid_low", 32'(bus.out_valid), 0);
      chk("elem_count", hs_cnt, 64);
      chk("sb_empty", sb.size(), 0);
      wait_clk();
      chk("done_width", 32'(bus.drain_done), 0);
      chk("done_pulses", done_cnt - d0, 1);
      chk("dropped", 32'(bus.dropped_write), 32'(exp_dropped));
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!reset_n) begin
         held_v = 1'b0;
      end else begin
         if (held_v && bus.out_valid) begin
            chk("hold_row", 32'(bus.out_row), 32'(held_row));
            chk("hold_col", 32'(bus.out_col), 32'(held_col));
            chk("hold_data", 32'(bus.out_data), 32'(held_data));
         end
         held_v = 1'b0;
         if (bus.drain_done) done_cnt++;
         if (bus.out_valid && bus.out_ready) begin
            hs_cnt++;
            if (sb.size() == 0) begin
               chk("sb_underflow", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("out_row", 32'(bus.out_row), e.r);
               chk("out_col", 32'(bus.out_col), e.c);
               chk("out_data", 32'(bus.out_data), 32'(e.d));
            end
         end else if (bus.out_valid) begin
            held_v    = 1'b1;
            held_row  = bus.out_row;
            held_col  = bus.out_col;
            held_data = bus.out_data;
         end
      end
   end

   initial begin
      clear_en();
      for (int b = 0; b < 4; b++) begin
         bus.buffer_row_write[b]    = '0;
         bus.buffer_column_write[b] = '0;
         bus.buffer_data_write[b]   = '0;
      end
      bus.drain_start = 1'b0;
      bus.out_ready   = 1'b0;
      zero_model();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", 32'(bus.busy), 1);
      chk("reset_wready", 32'(bus.write_ready), 0);
      chk("reset_valid", 32'(bus.out_valid), 0);
      chk("reset_done", 32'(bus.drain_done), 0);
      chk("reset_dropped", 32'(bus.dropped_write), 0);
      reset_n = 1'b1;
      wait_clear();
      tb_idle = 1'b1;

      drain(0, 1'b0, 1'b0, -1);

      issue(1, 2, 3, 8'h05);
      commit();
      issue(1, 2, 3, 8'hFF);
      commit();
      drain(0, 1'b0, 1'b0, -1);

      issue(1, 0, 1, 8'h7F);
      issue(2, 0, 2, 8'h80);
      commit();
      drain(1, 1'b0, 1'b0, -1);

      for (int k = 0; k < 3; k++) begin
         for (int n = 0; n < 12; n++) begin
            rand_writes();
            commit();
         end
         drain(2, 1'b1, 1'b0, -1);
      end

      issue(1, 2, 3, 20);
      commit();
      drain(0, 1'b0, 1'b1, -1);
      drain(0, 1'b0, 1'b0, -1);

      for (int n = 0; n < 10; n++) begin
         rand_writes();
         commit();
      end
      drain(0, 1'b0, 1'b0, 20);
      sb.delete();
      zero_model();
      exp_dropped = 1'b0;
      bus.out_ready = 1'b0;
      wait_clk();
      reset_n = 1'b1;
      wait_clear();
      drain(2, 1'b0, 1'b0, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
